pipe_elastic_stage: RTL and testbench

//  Parametrised elastic pipeline register that replaces the fixed if_id/id_ex/ex_mem/mem_wb latches.

---
 rtl/pipe_elastic_stage.sv | 91 +++++++++
 tb/tb_pipe_elastic_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_elastic_stage.sv
// Elastic valid/ready pipeline register: DEPTH-entry in-order buffer with optional
// same-cycle bypass, synchronous flush and a saturating downstream-stall counter.
module pipe_elastic_stage #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 2,
  parameter int PASSTHRU = 0,
  parameter int STALL_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [STALL_W-1:0]           stall_cnt
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]   FULL = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]   LAST = PTR_W'(DEPTH - 1);
  localparam logic [STALL_W-1:0] SAT  = '1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push;
  logic             pop;
  logic             bypass;
  logic             empty;

  // Explicit wrap so non-power-of-two depths index only valid entries.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (v == SAT) ? v : v + 1'b1;
  endfunction

  assign empty     = (count == '0);
  assign bypass    = (PASSTHRU != 0) && empty && in_valid && out_ready && !flush;
  assign in_ready  = (count < FULL) && !flush;
  assign out_valid = (!empty || bypass) && !flush;
  assign out_data  = bypass ? in_data : mem[rd_ptr];
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage stage: payload registers carry no reset.
  always_ff @(posedge clk) begin
    if (push && !bypass) mem[wr_ptr] <= in_data;
  end

  // Control stage: occupancy and pointers; rst over flush over push/pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (!bypass) begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                         stall_cnt <= '0;
    else if (out_valid && !out_ready) stall_cnt <= sat_inc(stall_cnt);
  end

`ifndef SYNTHESIS
  logic rst_seen;

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_seen <= 1'b1;
    end else if (rst_seen) begin
      a_count_range: assert (count <= FULL);
      a_no_push_full: assert (!(push && count == FULL));
      a_ctrl_known: assert (!$isunknown({in_valid, out_ready}));
    end
  end
`endif

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Scoreboard bench for pipe_elastic_stage: three configurations driven in lockstep,
// each checked against a queue-based model of an in-order buffer.
module tb_pipe_elastic_stage;

  localparam int N = 3;
  localparam int DEP  [N] = '{2, 3, 2};
  localparam int PAS  [N] = '{0, 0, 1};
  localparam int SMAX [N] = '{15, 65535, 65535};

  logic        clk = 1'b0;
  logic        rst;
  logic        flush     [N];
  logic        in_valid  [N];
  logic        in_ready  [N];
  logic        out_valid [N];
  logic        out_ready [N];
  logic [31:0] in_data   [N];
  logic [31:0] out_data  [N];
  logic [1:0]  count     [N];
  logic [3:0]  st0;
  logic [15:0] st1;
  logic [15:0] st2;

  logic [31:0] q [N][$];
  int          stall_m [N];
  bit          exp_ir  [N];
  bit          exp_ov  [N];
  int          exp_cnt [N];
  int          n_out   [N];
  bit          rst_done = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  pipe_elastic_stage #(.WIDTH(32), .DEPTH(2), .PASSTHRU(0), .STALL_W(4)) u0 (
    .clk(clk), .rst(rst), .flush(flush[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .count(count[0]), .stall_cnt(st0));

  pipe_elastic_stage #(.WIDTH(32), .DEPTH(3), .PASSTHRU(0), .STALL_W(16)) u1 (
    .clk(clk), .rst(rst), .flush(flush[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .count(count[1]), .stall_cnt(st1));

  pipe_elastic_stage #(.WIDTH(32), .DEPTH(2), .PASSTHRU(1), .STALL_W(16)) u2 (
    .clk(clk), .rst(rst), .flush(flush[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .count(count[2]), .stall_cnt(st2));

  function automatic int stall_of(int i);
    case (i)
      0:       return int'(st0);
      1:       return int'(st1);
      default: return int'(st2);
    endcase
  endfunction

  task automatic check(string name, int i, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < N; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      flush[i]     = 1'b0;
      in_data[i]   = $urandom;
    end
  endtask

  // One clock of stimulus: the model decides acceptance from queue occupancy alone.
  task automatic step();
    for (int i = 0; i < N; i++) begin
      int c;
      bit byp;
      c = q[i].size();
      if (!rst) begin
        byp = (PAS[i] != 0) && c == 0 && in_valid[i] && out_ready[i] && !flush[i];
        exp_cnt[i] = c;
        exp_ir[i]  = (c < DEP[i]) && !flush[i];
        exp_ov[i]  = (c != 0 || byp) && !flush[i];
        if (in_valid[i] && exp_ir[i]) q[i].push_back(in_data[i]);
      end
    end
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        q[i].delete();
        stall_m[i] = 0;
      end else begin
        if (exp_ov[i] && !out_ready[i] && stall_m[i] < SMAX[i]) stall_m[i]++;
        if (flush[i]) q[i].delete();
      end
    end
    #1;
  endtask

  // Monitor: mid-cycle sampling, pops the scoreboard on every completed output transfer.
  always @(negedge clk) begin
    if (rst_done && !rst) begin
      for (int i = 0; i < N; i++) begin
        check("in_ready", i, longint'(in_ready[i]), longint'(exp_ir[i]));
        check("out_valid", i, longint'(out_valid[i]), longint'(exp_ov[i]));
        check("count", i, longint'(count[i]), longint'(exp_cnt[i]));
        check("stall_cnt", i, longint'(stall_of(i)), longint'(stall_m[i]));
        if (out_valid[i]) begin
          if (q[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_data[%0d] got %0h expected no output at %0t", i, out_data[i], $time);
          end else begin
            check("out_data", i, longint'(out_data[i]), longint'(q[i][0]));
            if (out_ready[i]) begin
              void'(q[i].pop_front());
              n_out[i]++;
            end
          end
        end
      end
    end
  end

  initial begin
    int k;
    int base;
    for (int i = 0; i < N; i++) begin
      stall_m[i] = 0;
      n_out[i]   = 0;
    end
    idle();
    rst = 1'b1;
    for (int i = 0; i < N; i++) in_valid[i] = 1'b1;
    step();
    step();
    rst = 1'b0;
    rst_done = 1'b1;
    idle();
    step();

    // Fill u0 with backpressure, offer a third payload while full.
    in_valid[0] = 1'b1; in_data[0] = 32'hA; step();
    in_data[0] = 32'hB; step();
    in_data[0] = 32'hC; step(); step();
    in_valid[0] = 1'b0; out_ready[0] = 1'b1; step(); step();
    out_ready[0] = 1'b0; step();

    // Simultaneous push and pop at count=1.
    in_valid[0] = 1'b1; in_data[0] = 32'hA; step();
    in_data[0] = 32'hB; out_ready[0] = 1'b1; step();
    in_valid[0] = 1'b0; step(); step();
    out_ready[0] = 1'b0;

    // Flush at count=2 with a payload offered in the same cycle.
    in_valid[0] = 1'b1; in_data[0] = 32'h1; step();
    in_data[0] = 32'h2; step();
    flush[0] = 1'b1; in_data[0] = 32'hF; step();
    flush[0] = 1'b0; in_valid[0] = 1'b0; out_ready[0] = 1'b1; step(); step();
    out_ready[0] = 1'b0;

    // Saturate the 4-bit stall counter, then flush.
    in_valid[0] = 1'b1; in_data[0] = 32'h55; step();
    in_valid[0] = 1'b0;
    repeat (20) step();
    check("stall_sat", 0, longint'(st0), 64'd15);
    flush[0] = 1'b1; step();
    flush[0] = 1'b0; step();
    check("stall_after_flush", 0, longint'(st0), 64'd15);

    // DEPTH=3: ordered delivery of 1..7 across pointer wrap under random backpressure.
    base = n_out[1];
    k = 1;
    for (int cyc = 0; cyc < 200 && k <= 7; cyc++) begin
      bit acc;
      in_valid[1]  = 1'b1;
      in_data[1]   = k;
      out_ready[1] = 1'($urandom_range(0, 1));
      acc = q[1].size() < 3;
      step();
      if (acc) k++;
    end
    check("seq_issued", 1, longint'(k), 64'd8);
    in_valid[1] = 1'b0; out_ready[1] = 1'b1;
    for (int cyc = 0; cyc < 20 && q[1].size() != 0; cyc++) step();
    check("seq_delivered", 1, longint'(n_out[1] - base), 64'd7);
    out_ready[1] = 1'b0;

    // Zero-latency bypass on the PASSTHRU instance.
    in_valid[2] = 1'b1; out_ready[2] = 1'b1; in_data[2] = 32'hDEADBEEF; step();
    in_valid[2] = 1'b0; step();

    // Random traffic on all instances, including occasional flushes.
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++) begin
        in_valid[i]  = 1'($urandom_range(0, 1));
        in_data[i]   = $urandom;
        out_ready[i] = 1'($urandom_range(0, 2) != 0);
        flush[i]     = ($urandom_range(0, 15) == 0);
      end
      step();
    end

    // Reset with data buffered discards everything.
    idle();
    for (int i = 0; i < N; i++) in_valid[i] = 1'b1;
    step(); step();
    rst = 1'b1; step();
    rst = 1'b0; idle(); step();
    for (int i = 0; i < N; i++) check("count_after_rst", i, longint'(count[i]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
